// File: rtl/timer_irq_pkg.sv
// Shared constants and types for the memory-mapped countdown timer.
// Optional prescaler register enabled with TIMER_PRESCALE_EN.
package timer_irq_pkg;

    // Default word-aligned base of the 16-byte register window
    localparam logic [31:0] TMR_DEFAULT_BASE = 32'h0000_7F00;

    localparam int unsigned TMR_ADDR_W = 30;
    localparam int unsigned TMR_DATA_W = 32;
    localparam int unsigned TMR_CTRL_W = 4;
    localparam int unsigned TMR_PSC_W  = 16;

    // Word offsets inside the window (Addr[1:0])
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_PSC    = 2'd3;

    // CTRL.Mode values; 2 and 3 are reserved and act as one-shot
    localparam logic [1:0] TMR_MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] TMR_MODE_PERIODIC = 2'd1;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_LOAD = 2'd1,
        TMR_CNT  = 2'd2,
        TMR_INT  = 2'd3
    } tmr_state_e;

    // CTRL register layout, bit 3 down to bit 0
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tmr_ctrl_t;

endpackage

// File: rtl/timer_irq_if.sv
// CPU data-bus slave port of the timer plus its interrupt line.
interface timer_irq_if;
    import timer_irq_pkg::*;

    logic [TMR_ADDR_W-1:0] Addr;
    logic                  WE;
    logic [TMR_DATA_W-1:0] DataIn;
    logic [TMR_DATA_W-1:0] DataOut;
    logic                  IRQ;

    modport master (
        output Addr,
        output WE,
        output DataIn,
        input  DataOut,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  DataIn,
        output DataOut,
        output IRQ
    );

endinterface

// File: rtl/timer_irq_prescaler.sv
// Tick divider for the countdown; only present when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_irq_prescaler
    import timer_irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic [TMR_PSC_W-1:0] psc,
    output logic                 tick
);

    logic [TMR_PSC_W-1:0] div;

    // A tick is issued on the cycle the divider reaches the programmed value
    assign tick = (div == psc);

    // Divider counts up, wrapping to 0 after each tick or on a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (clr || tick) begin
            div <= '0;
        end else begin
            div <= div + TMR_PSC_W'(1);
        end
    end

endmodule
`endif

// File: rtl/timer_irq.sv
// Programmable countdown timer on the CPU data bus, driving one CP0 HWInt line.
// Define TIMER_PRESCALE_EN to add the PSC register at offset 0xC.
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR = TMR_DEFAULT_BASE,
    parameter int unsigned  WIDTH     = 32
) (
    input  logic        clk,
    input  logic        reset,
    timer_irq_if.slave  bus
);

    tmr_state_e       state, state_n;
    tmr_ctrl_t        ctrl, ctrl_n;
    logic [WIDTH-1:0] preset, preset_n;
    logic [WIDTH-1:0] count, count_n;
    logic             irq_flag, irq_flag_n;

    logic             hit;
    logic [1:0]       off;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             tick;
    logic [31:0]      rdata;

    // Address decode of the 4-word window
    assign hit       = (bus.Addr[29:2] == BASE_ADDR[31:4]);
    assign off       = bus.Addr[1:0];
    assign wr_ctrl   = bus.WE && hit && (off == TMR_CTRL);
    assign wr_preset = bus.WE && hit && (off == TMR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [TMR_PSC_W-1:0] psc, psc_n;
    logic                 wr_psc;
    logic                 div_clr;

    assign wr_psc  = bus.WE && hit && (off == TMR_PSC);
    assign div_clr = (state == TMR_LOAD) || wr_ctrl || wr_preset || wr_psc;

    timer_irq_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .psc   (psc),
        .tick  (tick)
    );

    // PSC register update
    always_comb begin
        psc_n = psc;
        if (wr_psc) begin
            psc_n = bus.DataIn[TMR_PSC_W-1:0];
        end
    end

    // PSC register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc <= '0;
        end else begin
            psc <= psc_n;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // State and register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= TMR_IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_n;
            ctrl     <= ctrl_n;
            preset   <= preset_n;
            count    <= count_n;
            irq_flag <= irq_flag_n;
        end
    end

    // Countdown FSM with bus writes overriding it on the same edge
    always_comb begin
        state_n    = state;
        ctrl_n     = ctrl;
        preset_n   = preset;
        count_n    = count;
        irq_flag_n = irq_flag;

        case (state)
            TMR_IDLE: begin
                if (ctrl.en) begin
                    state_n = TMR_LOAD;
                end
            end
            TMR_LOAD: begin
                count_n = preset;
                // Periodic pulse lasts exactly the one cycle after INT
                if (ctrl.mode == TMR_MODE_PERIODIC) begin
                    irq_flag_n = 1'b0;
                end
                // A zero preset expires at once, giving a 2-cycle period
                if (preset == '0) begin
                    state_n = TMR_INT;
                end else begin
                    state_n = TMR_CNT;
                end
            end
            TMR_CNT: begin
                if (!ctrl.en) begin
                    state_n = TMR_IDLE;
                end else if (tick) begin
                    if (count <= WIDTH'(1)) begin
                        count_n = '0;
                        state_n = TMR_INT;
                    end else begin
                        count_n = count - WIDTH'(1);
                    end
                end
            end
            TMR_INT: begin
                irq_flag_n = 1'b1;
                if (ctrl.mode == TMR_MODE_PERIODIC) begin
                    state_n = TMR_LOAD;
                end else begin
                    ctrl_n.en = 1'b0;
                    state_n   = TMR_IDLE;
                end
            end
            default: begin
                state_n = TMR_IDLE;
            end
        endcase

        // Reprogramming restarts from IDLE and never disturbs COUNT
        if (wr_ctrl || wr_preset) begin
            state_n    = TMR_IDLE;
            irq_flag_n = 1'b0;
            count_n    = count;
        end
        if (wr_ctrl) begin
            ctrl_n = tmr_ctrl_t'(bus.DataIn[TMR_CTRL_W-1:0]);
        end
        if (wr_preset) begin
            preset_n = bus.DataIn[WIDTH-1:0];
        end
    end

    // Side-effect-free read mux, zero for unmapped addresses
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                TMR_CTRL:   rdata = 32'(ctrl);
                TMR_PRESET: rdata = 32'(preset);
                TMR_COUNT:  rdata = 32'(count);
`ifdef TIMER_PRESCALE_EN
                TMR_PSC:    rdata = 32'(psc);
`endif
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.DataOut = rdata;
    assign bus.IRQ     = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq; also covers TIMER_PRESCALE_EN when defined.
module tb_timer_irq;
    import timer_irq_pkg::*;

    // 0x0000_7F00 >> 2
    localparam logic [29:0] BASE_W = 30'h0000_1FC0;

    logic clk;
    logic reset;
    int   nvec;
    int   nmis;
    logic [31:0] rd;

    timer_irq_if bus ();

    timer_irq #(
        .BASE_ADDR (32'h0000_7F00),
        .WIDTH     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge performs the write
    task automatic bus_write(input logic [2:0] woff, input logic [31:0] data);
        bus.Addr   = BASE_W + 30'(woff);
        bus.DataIn = data;
        bus.WE     = 1'b1;
        @(negedge clk);
        bus.WE     = 1'b0;
    endtask

    task automatic rd_raw(input logic [29:0] addr, output logic [31:0] d);
        bus.WE   = 1'b0;
        bus.Addr = addr;
        #1;
        d = bus.DataOut;
    endtask

    task automatic rd_reg(input logic [2:0] woff, output logic [31:0] d);
        rd_raw(BASE_W + 30'(woff), d);
    endtask

    initial begin
        nvec       = 0;
        nmis       = 0;
        reset      = 1'b0;
        bus.Addr   = '0;
        bus.WE     = 1'b0;
        bus.DataIn = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(bus.IRQ), 32'd0);
        rd_reg(3'd0, rd); chk("rst_ctrl", rd, 32'd0);
        rd_reg(3'd1, rd); chk("rst_preset", rd, 32'd0);
        rd_reg(3'd2, rd); chk("rst_count", rd, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // One-shot: PRESET=5, CTRL=0x9, IRQ after edge 8
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("m0_irq_e%0d", k), 32'(bus.IRQ), (k == 8) ? 32'd1 : 32'd0);
            if (k == 3) begin
                rd_reg(3'd2, rd); chk("m0_count_e3", rd, 32'd4);
            end
        end
        rd_reg(3'd2, rd); chk("m0_count_done", rd, 32'd0);
        rd_reg(3'd0, rd); chk("m0_ctrl_done", rd, 32'h8);
        chk("m0_mode", 32'(rd[2:1]), 32'(TMR_MODE_ONESHOT));
        rd_reg(3'd1, rd); chk("m0_preset", rd, 32'd5);
        repeat (3) @(negedge clk);
        chk("m0_irq_hold", 32'(bus.IRQ), 32'd1);
        bus_write(3'd0, 32'h0);
        chk("m0_irq_clear", 32'(bus.IRQ), 32'd0);

        // Periodic: PRESET=3, CTRL=0xB, pulses after edges 6,11,16,21
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            chk($sformatf("m1_irq_e%0d", k), 32'(bus.IRQ),
                (k >= 6 && ((k - 6) % 5) == 0) ? 32'd1 : 32'd0);
        end
        bus_write(3'd0, 32'h0);
        chk("m1_stop_irq", 32'(bus.IRQ), 32'd0);

        // Masked one-shot: PRESET=4, CTRL=0x1, IRQ stays low
        bus_write(3'd1, 32'd4);
        bus_write(3'd0, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("mask_irq_e%0d", k), 32'(bus.IRQ), 32'd0);
        end
        chk("mask_flag_set", 32'(dut.irq_flag), 32'd1);
        rd_reg(3'd0, rd); chk("mask_ctrl", rd, 32'h0);
        rd_reg(3'd2, rd); chk("mask_count", rd, 32'd0);

        // Abort at COUNT=2: COUNT freezes, FSM back in IDLE
        bus_write(3'd0, 32'h1);
        repeat (4) @(negedge clk);
        rd_reg(3'd2, rd); chk("abort_pre", rd, 32'd2);
        bus_write(3'd0, 32'h0);
        rd_reg(3'd2, rd); chk("abort_count", rd, 32'd2);
        repeat (3) @(negedge clk);
        rd_reg(3'd2, rd); chk("abort_count_hold", rd, 32'd2);
        chk("abort_state", 32'(dut.state), 32'd0);
        chk("abort_irq", 32'(bus.IRQ), 32'd0);

        // Bus decode
        bus_write(3'd2, 32'h55);
        rd_reg(3'd2, rd); chk("dec_count_ro", rd, 32'd2);
        rd_reg(3'd4, rd); chk("dec_off10", rd, 32'd0);
        rd_raw(30'h0000_0001, rd); chk("dec_nohit", rd, 32'd0);
        rd_raw(30'h3FFF_FFC1, rd); chk("dec_alias", rd, 32'd0);
`ifdef TIMER_PRESCALE_EN
        // Prescaled one-shot: PSC=2, PRESET=2, IRQ after edge 2*3+3
        bus_write(3'd3, 32'd2);
        rd_reg(3'd3, rd); chk("psc_rd", rd, 32'd2);
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("psc_irq_e%0d", k), 32'(bus.IRQ), (k == 9) ? 32'd1 : 32'd0);
        end
        bus_write(3'd0, 32'h0);
        bus_write(3'd3, 32'd0);
`else
        bus_write(3'd3, 32'h1234);
        rd_reg(3'd3, rd); chk("psc_unmapped", rd, 32'd0);
        rd_reg(3'd1, rd); chk("psc_wr_preset", rd, 32'd4);
`endif

        // PRESET=0 periodic: pulses after edges 3,5,7,9
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'hB);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("p0_irq_e%0d", k), 32'(bus.IRQ),
                (k >= 3 && (k % 2) == 1) ? 32'd1 : 32'd0);
        end
        bus_write(3'd0, 32'h0);

        // Asynchronous reset while IRQ is high
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'h9);
        repeat (5) @(negedge clk);
        chk("ar_irq_pre", 32'(bus.IRQ), 32'd1);
        #2 reset = 1'b0;
        #1 chk("ar_irq", 32'(bus.IRQ), 32'd0);
        rd_reg(3'd0, rd); chk("ar_ctrl", rd, 32'd0);
        rd_reg(3'd1, rd); chk("ar_preset", rd, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-count at COUNT=7
        bus_write(3'd1, 32'd9);
        bus_write(3'd0, 32'h9);
        repeat (4) @(negedge clk);
        rd_reg(3'd2, rd); chk("ar2_count_pre", rd, 32'd7);
        #1 reset = 1'b0;
        #1 rd_reg(3'd2, rd); chk("ar2_count", rd, 32'd0);
        rd_reg(3'd0, rd); chk("ar2_ctrl", rd, 32'd0);
        rd_reg(3'd1, rd); chk("ar2_preset", rd, 32'd0);
        chk("ar2_irq", 32'(bus.IRQ), 32'd0);
        chk("ar2_state", 32'(dut.state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
